// File: rtl/game_pkg.sv
// Shared types and default point values for the pickup tracker.
package game_pkg;

  typedef enum logic [1:0] {
    COIN  = 2'd0,
    POWER = 2'd1,
    GOAL  = 2'd2,
    DECOR = 2'd3
  } obj_kind_t;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    END   = 2'd2
  } game_state_t;

  localparam int DEF_PTS_COIN  = 1;
  localparam int DEF_PTS_POWER = 5;

endpackage

// File: rtl/score_accum.sv
// Saturating score register. SCORE_BCD_EN selects packed-BCD storage with
// per-digit carry; otherwise the score is plain binary.
module score_accum #(
  parameter int DIGITS = 2,
  parameter int INC_W  = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic [INC_W-1:0]      add_val,
  output logic [4*DIGITS-1:0]   score
);

  localparam int SW = 4 * DIGITS;

  logic [SW-1:0] score_reg;
  logic [SW-1:0] sum_next;

`ifdef SCORE_BCD_EN
  logic [INC_W-1:0] rem;
  logic [4:0]       digit_sum;
  logic             carry;

  // The binary increment is peeled into decimal digits while rippling the carry.
  always_comb begin
    rem       = add_val;
    carry     = 1'b0;
    digit_sum = '0;
    sum_next  = '0;
    for (int d = 0; d < DIGITS; d++) begin
      digit_sum = {1'b0, score_reg[4*d +: 4]} + 5'(rem % 10) + {4'd0, carry};
      rem       = INC_W'(rem / 10);
      if (digit_sum > 5'd9) begin
        digit_sum = digit_sum - 5'd10;
        carry     = 1'b1;
      end else begin
        carry     = 1'b0;
      end
      sum_next[4*d +: 4] = digit_sum[3:0];
    end
    if (carry || (rem != '0)) sum_next = {DIGITS{4'h9}};
  end
`else
  localparam int AW = ((SW > INC_W) ? SW : INC_W) + 1;
  logic [AW-1:0] wide;

  always_comb begin
    wide     = AW'(score_reg) + AW'(add_val);
    sum_next = (wide > AW'({SW{1'b1}})) ? {SW{1'b1}} : wide[SW-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_reg <= '0;
    end else if (clr) begin
      score_reg <= '0;
    end else if (add_en) begin
      score_reg <= sum_next;
    end
  end

  assign score = score_reg;

endmodule

// File: rtl/pickup_tracker.sv
// Pickup overlap search, per-frame collection commit and game state machine.
// Score format is chosen by SCORE_BCD_EN (see score_accum).
module pickup_tracker
  import game_pkg::*;
#(
  parameter int N_OBJ        = 8,
  parameter int COORD_W      = 10,
  parameter int WORLD_W      = 13,
  parameter int OBJ_SIZE     = 40,
  parameter int SCORE_DIGITS = 2,
  parameter int PTS_COIN     = DEF_PTS_COIN,
  parameter int PTS_POWER    = DEF_PTS_POWER,
  localparam int SEL_W       = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [COORD_W-1:0]        draw_x,
  input  logic [COORD_W-1:0]        draw_y,
  input  logic [WORLD_W-1:0]        scroll_x,
  input  logic                      frame_start,
  input  logic                      start,
  input  logic                      restart,
  input  logic                      hero_opaque,
  input  logic [N_OBJ*WORLD_W-1:0]  obj_x,
  input  logic [N_OBJ*COORD_W-1:0]  obj_y,
  input  logic [N_OBJ*2-1:0]        obj_kind,
  output logic [SEL_W-1:0]          obj_sel,
  output logic [5:0]                obj_u,
  output logic [5:0]                obj_v,
  output logic                      obj_cover,
  input  logic                      sprite_opaque,
  output logic                      obj_pix_on,
  output logic [N_OBJ-1:0]          collected,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic                      power,
  output logic [1:0]                game_state,
  output logic                      goal_evt
);

  localparam int WX_W    = WORLD_W + 1;
  localparam int XE_W    = WORLD_W + 2;
  localparam int YE_W    = COORD_W + 1;
  localparam int MAX_PTS = (PTS_COIN > PTS_POWER) ? PTS_COIN : PTS_POWER;
  localparam int INC_W   = $clog2(N_OBJ * MAX_PTS + 1);

  game_state_t      state_reg;
  logic [N_OBJ-1:0] collected_reg;
  logic [N_OBJ-1:0] pending_reg;
  logic             power_reg;
  logic             goal_evt_reg;

  logic [WX_W-1:0]  wx;
  logic [N_OBJ-1:0] cover_vec;
  logic [5:0]       u_arr    [N_OBJ];
  logic [5:0]       v_arr    [N_OBJ];
  obj_kind_t        kind_arr [N_OBJ];
  logic [INC_W-1:0] pts_arr  [N_OBJ];

  // Extra top bit keeps the world x from wrapping at the edge of the world.
  assign wx = WX_W'(draw_x) + WX_W'(scroll_x);

  for (genvar gi = 0; gi < N_OBJ; gi++) begin : g_obj
    logic [XE_W-1:0] ox;
    logic [YE_W-1:0] oy;
    logic            in_x;
    logic            in_y;

    assign ox   = XE_W'(obj_x[gi*WORLD_W +: WORLD_W]);
    assign oy   = YE_W'(obj_y[gi*COORD_W +: COORD_W]);
    assign in_x = ({1'b0, wx} >= ox) && ({1'b0, wx} < ox + XE_W'(OBJ_SIZE));
    assign in_y = (YE_W'(draw_y) >= oy) && (YE_W'(draw_y) < oy + YE_W'(OBJ_SIZE));

    assign cover_vec[gi] = in_x && in_y && !collected_reg[gi];
    assign u_arr[gi]     = 6'(wx - ox[WX_W-1:0]);
    assign v_arr[gi]     = 6'(draw_y - oy[COORD_W-1:0]);
    assign kind_arr[gi]  = obj_kind_t'(obj_kind[2*gi +: 2]);
    assign pts_arr[gi]   = (kind_arr[gi] == COIN)  ? INC_W'(PTS_COIN)  :
                           (kind_arr[gi] == POWER) ? INC_W'(PTS_POWER) : '0;
  end

  logic [SEL_W-1:0] sel;

  // Scanning from the top index down leaves the lowest covering index in sel.
  always_comb begin
    sel = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (cover_vec[i]) sel = SEL_W'(i);
    end
  end

  assign obj_sel    = sel;
  assign obj_u      = u_arr[sel];
  assign obj_v      = v_arr[sel];
  assign obj_cover  = |cover_vec;
  assign obj_pix_on = obj_cover && sprite_opaque;

  logic             hit;
  logic [N_OBJ-1:0] hit_mask;
  logic [N_OBJ-1:0] new_bits;
  logic [INC_W-1:0] inc;
  logic             any_power;
  logic             any_goal;
  logic             commit;

  assign hit      = (state_reg == PLAY) && obj_pix_on && hero_opaque &&
                    (kind_arr[sel] != DECOR);
  assign hit_mask = hit ? (N_OBJ'(1) << sel) : '0;
  assign new_bits = pending_reg & ~collected_reg;
  assign commit   = frame_start && (state_reg == PLAY);

  always_comb begin
    inc       = '0;
    any_power = 1'b0;
    any_goal  = 1'b0;
    for (int i = 0; i < N_OBJ; i++) begin
      if (new_bits[i]) begin
        inc = inc + pts_arr[i];
        if (kind_arr[i] == POWER) any_power = 1'b1;
        if (kind_arr[i] == GOAL)  any_goal  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= TITLE;
      collected_reg <= '0;
      pending_reg   <= '0;
      power_reg     <= 1'b0;
      goal_evt_reg  <= 1'b0;
    end else begin
      goal_evt_reg <= 1'b0;
      case (state_reg)
        TITLE: if (frame_start && start) state_reg <= PLAY;
        PLAY: begin
          if (frame_start) begin
            // A hit on the commit cycle starts the next pending set.
            collected_reg <= collected_reg | pending_reg;
            pending_reg   <= hit_mask;
            if (any_power) power_reg <= 1'b1;
            if (any_goal) begin
              state_reg    <= END;
              goal_evt_reg <= 1'b1;
            end
          end else begin
            pending_reg <= pending_reg | hit_mask;
          end
        end
        END: begin
          if (restart) begin
            state_reg     <= TITLE;
            collected_reg <= '0;
            pending_reg   <= '0;
            power_reg     <= 1'b0;
          end
        end
        default: state_reg <= TITLE;
      endcase
    end
  end

  score_accum #(
    .DIGITS (SCORE_DIGITS),
    .INC_W  (INC_W)
  ) u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     ((state_reg == END) && restart),
    .add_en  (commit),
    .add_val (inc),
    .score   (score)
  );

  assign collected  = collected_reg;
  assign power      = power_reg;
  assign game_state = state_reg;
  assign goal_evt   = goal_evt_reg;

endmodule

// File: tb/tb_pickup_tracker.sv
// Directed bench: main instance with default points, second instance with a
// large coin value to reach score saturation.
module tb_pickup_tracker;
  import game_pkg::*;

`ifdef SCORE_BCD_EN
  localparam int SAT_COIN = 92;
  localparam logic [7:0] SC1 = 8'h92, SC2 = 8'h97, SC3 = 8'h99, MAIN11 = 8'h11;
`else
  localparam int SAT_COIN = 248;
  localparam logic [7:0] SC1 = 8'hF8, SC2 = 8'hFD, SC3 = 8'hFF, MAIN11 = 8'h0B;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [9:0]   draw_x, draw_y;
  logic [12:0]  scroll_x;
  logic         frame_start, start, restart, hero_opaque, sprite_opaque;
  logic [103:0] obj_x;
  logic [79:0]  obj_y;
  logic [15:0]  obj_kind;

  logic [2:0] obj_sel, s_obj_sel;
  logic [5:0] obj_u, obj_v, s_obj_u, s_obj_v;
  logic       obj_cover, obj_pix_on, s_obj_cover, s_obj_pix_on;
  logic [7:0] collected, score, s_collected, s_score;
  logic       power, goal_evt, s_power, s_goal_evt;
  logic [1:0] game_state, s_game_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] coll;
    logic [7:0] sc;
    logic       pwr;
    logic [1:0] st;
    logic       gev;
    logic       sat_en;
    logic [7:0] sat_sc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pickup_tracker dut (
    .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
    .scroll_x(scroll_x), .frame_start(frame_start), .start(start),
    .restart(restart), .hero_opaque(hero_opaque), .obj_x(obj_x), .obj_y(obj_y),
    .obj_kind(obj_kind), .obj_sel(obj_sel), .obj_u(obj_u), .obj_v(obj_v),
    .obj_cover(obj_cover), .sprite_opaque(sprite_opaque), .obj_pix_on(obj_pix_on),
    .collected(collected), .score(score), .power(power),
    .game_state(game_state), .goal_evt(goal_evt)
  );

  pickup_tracker #(.PTS_COIN(SAT_COIN)) sat_dut (
    .clk(clk), .reset_n(reset_n), .draw_x(draw_x), .draw_y(draw_y),
    .scroll_x(scroll_x), .frame_start(frame_start), .start(start),
    .restart(restart), .hero_opaque(hero_opaque), .obj_x(obj_x), .obj_y(obj_y),
    .obj_kind(obj_kind), .obj_sel(s_obj_sel), .obj_u(s_obj_u), .obj_v(s_obj_v),
    .obj_cover(s_obj_cover), .sprite_opaque(sprite_opaque), .obj_pix_on(s_obj_pix_on),
    .collected(s_collected), .score(s_score), .power(s_power),
    .game_state(s_game_state), .goal_evt(s_goal_evt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [7:0] coll, input logic [7:0] sc,
                      input logic pwr, input game_state_t st, input logic gev,
                      input logic sat_en, input logic [7:0] sat_sc);
    exp_t e;
    e.tag = tag; e.coll = coll; e.sc = sc; e.pwr = pwr; e.st = st;
    e.gev = gev; e.sat_en = sat_en; e.sat_sc = sat_sc;
    sb.push_back(e);
  endtask

  task automatic pixel(input int x, input int y);
    draw_x = 10'(x);
    draw_y = 10'(y);
    #1;
  endtask

  task automatic hit(input int x, input int y);
    draw_x = 10'(x); draw_y = 10'(y);
    hero_opaque = 1'b1; sprite_opaque = 1'b1;
    tick();
    hero_opaque = 1'b0; sprite_opaque = 1'b0;
  endtask

  // Pulses frame_start (optionally with a coincident hit) and retires expectations.
  task automatic frame(input bit with_hit, input int x, input int y);
    exp_t e;
    if (with_hit) begin
      draw_x = 10'(x); draw_y = 10'(y);
      hero_opaque = 1'b1; sprite_opaque = 1'b1;
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; hero_opaque = 1'b0; sprite_opaque = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".collected"}, collected, e.coll);
      chk({e.tag, ".score"}, score, e.sc);
      chk({e.tag, ".power"}, power, e.pwr);
      chk({e.tag, ".state"}, game_state, e.st);
      chk({e.tag, ".goal_evt"}, goal_evt, e.gev);
      if (e.sat_en) chk({e.tag, ".sat_score"}, s_score, e.sat_sc);
    end
  endtask

  initial begin
    int        ox_t [8] = '{160, 320, 240, 980, 500, 600, 700, 230};
    int        oy_t [8] = '{300, 300, 300, 300, 100, 300, 300, 300};
    obj_kind_t k_t  [8] = '{COIN, COIN, POWER, GOAL, DECOR, COIN, POWER, DECOR};
    for (int i = 0; i < 8; i++) begin
      obj_x[i*13 +: 13]  = 13'(ox_t[i]);
      obj_y[i*10 +: 10]  = 10'(oy_t[i]);
      obj_kind[i*2 +: 2] = k_t[i];
    end
    reset_n = 1'b0; draw_x = '0; draw_y = '0; scroll_x = '0;
    frame_start = 1'b0; start = 1'b0; restart = 1'b0;
    hero_opaque = 1'b0; sprite_opaque = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    chk("rst.collected", collected, 8'h00);
    chk("rst.score", score, 8'h00);
    chk("rst.power", power, 1'b0);
    chk("rst.state", game_state, TITLE);
    chk("rst.goal_evt", goal_evt, 1'b0);

    pixel(170, 310);
    chk("cov.in", obj_cover, 1'b1);
    chk("cov.sel", obj_sel, 3'd0);
    chk("cov.u", obj_u, 6'd10);
    chk("cov.v", obj_v, 6'd10);
    chk("cov.pix_off", obj_pix_on, 1'b0);
    sprite_opaque = 1'b1; #1;
    chk("cov.pix_on", obj_pix_on, 1'b1);
    sprite_opaque = 1'b0;
    pixel(199, 339);
    chk("edge.in", obj_cover, 1'b1);
    chk("edge.u", obj_u, 6'd39);
    chk("edge.v", obj_v, 6'd39);
    pixel(200, 310); chk("edge.x_out", obj_cover, 1'b0);
    pixel(159, 310); chk("edge.x_lo", obj_cover, 1'b0);
    pixel(170, 340); chk("edge.y_out", obj_cover, 1'b0);
    pixel(245, 310);
    chk("prio.sel", obj_sel, 3'd2);
    chk("prio.u", obj_u, 6'd5);

    hit(170, 310);
    start = 1'b1;
    push("enter_play", 8'h00, 8'h00, 1'b0, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);
    start = 1'b0;

    hit(170, 310);
    hit(330, 310);
    reset_n = 1'b0; #2;
    chk("midrst.collected", collected, 8'h00);
    chk("midrst.score", score, 8'h00);
    chk("midrst.state", game_state, TITLE);
    tick();
    reset_n = 1'b1;

    start = 1'b1;
    push("replay", 8'h00, 8'h00, 1'b0, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);
    start = 1'b0;
    push("no_pending", 8'h00, 8'h00, 1'b0, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);

    hit(170, 310);
    push("coin0", 8'h01, 8'h01, 1'b0, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);
    pixel(170, 310);
    chk("coin0.hidden", obj_cover, 1'b0);
    hit(170, 310);
    push("coin0_again", 8'h01, 8'h01, 1'b0, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);

    hit(250, 310);
    push("power", 8'h05, 8'h06, 1'b1, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);

    pixel(232, 310);
    chk("decor.sel", obj_sel, 3'd7);
    hit(232, 310);
    hit(330, 310);
    push("coin1_decor", 8'h07, 8'h07, 1'b1, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);

    push("coincide_a", 8'h07, 8'h07, 1'b1, PLAY, 1'b0, 1'b0, 8'h00);
    frame(1, 610, 310);
    push("coincide_b", 8'h27, 8'h08, 1'b1, PLAY, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);

    scroll_x = 13'd900;
    pixel(90, 310);
    chk("goal.sel", obj_sel, 3'd3);
    chk("goal.u", obj_u, 6'd10);
    hit(90, 310);
    push("goal", 8'h2F, 8'h08, 1'b1, END, 1'b1, 1'b0, 8'h00);
    frame(0, 0, 0);
    tick();
    chk("goal.pulse_once", goal_evt, 1'b0);

    scroll_x = 13'd0;
    hit(710, 310);
    push("end_frozen", 8'h2F, 8'h08, 1'b1, END, 1'b0, 1'b0, 8'h00);
    frame(0, 0, 0);

    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart.state", game_state, TITLE);
    chk("restart.collected", collected, 8'h00);
    chk("restart.score", score, 8'h00);
    chk("restart.power", power, 1'b0);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    start = 1'b1;
    push("sat_play", 8'h00, 8'h00, 1'b0, PLAY, 1'b0, 1'b1, 8'h00);
    frame(0, 0, 0);
    start = 1'b0;
    hit(170, 310);
    push("sat_coin", 8'h01, 8'h01, 1'b0, PLAY, 1'b0, 1'b1, SC1);
    frame(0, 0, 0);
    hit(250, 310);
    push("sat_pow1", 8'h05, 8'h06, 1'b1, PLAY, 1'b0, 1'b1, SC2);
    frame(0, 0, 0);
    hit(710, 310);
    push("sat_pow2", 8'h45, MAIN11, 1'b1, PLAY, 1'b0, 1'b1, SC3);
    frame(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pickup_tracker.md
# pickup_tracker

Parametrised successor to the frame compositor's hard-wired coin, power-up and goal logic. It tracks N scrollable pickup objects, detects pixel-exact overlap between each object and the hero during the raster scan, and commits collections once per frame. It also owns the score, the power flag and the title/play/end game state. It sits between the VGA raster counters, the sprite ROMs and the colour-value mux.

## Interface
- N_OBJ, 8: number of pickup objects (1..32).
- COORD_W, 10: width of screen coordinates.
- WORLD_W, 13: width of world (scrolled) coordinates.
- OBJ_SIZE, 40: object edge length in pixels; objects are square.
- SCORE_DIGITS, 2: number of score digits; the score bus is 4*SCORE_DIGITS bits.
- PTS_COIN, 1: points awarded per coin.
- PTS_POWER, 5: points awarded per power-up.

Ports:
- clk in 1: pixel clock.
- reset_n in 1: asynchronous, active-low reset.
- draw_x, draw_y in COORD_W: current raster pixel.
- scroll_x in WORLD_W: horizontal world offset.
- frame_start in 1: one-cycle pulse at the first pixel of each frame.
- start in 1: level-sensitive start request (the keypress).
- restart in 1: return request from the end screen.
- hero_opaque in 1: the hero sprite is non-transparent at the current pixel.
- obj_x in N_OBJ*WORLD_W: object world x positions, flattened, object 0 in the LSBs.
- obj_y in N_OBJ*COORD_W: object y positions, flattened.
- obj_kind in N_OBJ*2: object kinds, flattened.
- obj_sel out $clog2(N_OBJ): index of the object covering the current pixel.
- obj_u, obj_v out 6: local sprite coordinates of that object.
- obj_cover out 1: some uncollected object covers the current pixel (combinational).
- sprite_opaque in 1: ROM answer for (obj_kind[obj_sel], obj_u, obj_v), returned in the same cycle.
- obj_pix_on out 1: the object pixel should be drawn (obj_cover && sprite_opaque).
- collected out N_OBJ: collected mask.
- score out 4*SCORE_DIGITS: the score.
- power out 1: power-up active; drives the hero palette.
- game_state out 2: current game state.
- goal_evt out 1: one-cycle pulse when the game enters END.

## Operation
- World x is computed as wx = draw_x + scroll_x in WORLD_W+1 bits, with no wrap.
- An object covers the pixel when obj_x ≤ wx < obj_x+OBJ_SIZE and obj_y ≤ draw_y < obj_y+OBJ_SIZE (half-open bounds).
- A collected object never covers a pixel.
- When several objects overlap, the lowest index wins obj_sel.
- obj_u = wx−obj_x and obj_v = draw_y−obj_y.
- Kinds:
  - 0 COIN: adds PTS_COIN.
  - 1 POWER: adds PTS_POWER and sets power.
  - 2 GOAL: ends the game.
  - 3 DECOR: drawn, never collectable.
- A hit occurs when game_state==PLAY, obj_pix_on is high, hero_opaque is high and kind!=DECOR. A hit sets pending[obj_sel].
- FSM:
  - TITLE → PLAY on the first frame_start with start==1.
  - PLAY → END on the commit that contains any GOAL bit; goal_evt pulses in that cycle.
  - END → TITLE on restart==1. This clears collected, pending, score and power.
- Commit happens on frame_start while in PLAY:
  - collected |= pending.
  - score increases by the sum over newly collected bits of the kind's points.
  - power is set if any newly collected object is POWER.
  - pending is cleared.
- Hit/commit collision: a hit arriving in the same cycle as frame_start is loaded into the new pending set, not the committed one.
- Score saturation:
  - The score saturates at its maximum and never wraps.
  - The summed increment is computed in at least $clog2(N_OBJ*PTS_POWER+1) bits.
- Hits are ignored in TITLE and END. The mask, score and power are frozen in END.
- Reset values (on reset_n low, at any point mid-frame):
  - collected=0, pending=0, score=0, power=0, game_state=TITLE, goal_evt=0.

## Timing
- obj_sel, obj_u, obj_v, obj_cover and obj_pix_on are combinational, with zero latency.
- Hit detection is registered into pending one cycle after the pixel.
- collected, score and power update in the cycle after frame_start. They are therefore stable for the whole following frame.
- The score adder may be a two-cycle pipeline, provided it completes before the next frame_start.
- A collected object disappears from the display starting with the next frame.

## Configuration
- SCORE_BCD_EN defined: score is packed BCD, SCORE_DIGITS digits, and saturates at all-nines. Addition uses per-digit carry.
- SCORE_BCD_EN undefined: score is plain binary and saturates at 2^(4*SCORE_DIGITS)−1.

## Structure
- game_pkg holds:
  - obj_kind_t enum (COIN, POWER, GOAL, DECOR).
  - game_state_t enum (TITLE, PLAY, END).
  - The default point constants.
- One sub-module, score_accum, holds the saturating add in binary or BCD under SCORE_BCD_EN.
- Object-cover search, pending/collected registers and the FSM stay in pickup_tracker.

## Test plan
- Reset mid-frame with pending=0x3: after release, collected=0, score=0, game_state=TITLE.
- Setup: start held, frame_start; coin 0 at (160,300), scroll_x=0; hero_opaque and sprite_opaque high at (170,310). Response: collected[0]=1 and score=1 after the next frame_start. Subsequent overlaps add nothing.
- POWER at (240,300) hit in the same frame as coin 1: score=6 and power=1 at the next commit.
- scroll_x=900, GOAL at world x 980, hit: goal_evt pulses once and the state is END. Further hits leave the score unchanged.
- Saturation: with SCORE_BCD_EN, score=0x97 plus POWER gives 0x99. Without the macro, score=0xFD plus POWER gives 0xFF.
- Hit coincident with frame_start: the bit is not committed in that frame and commits at the following frame_start.
